operand_fetch_stage: RTL and testbench
======================================

// Module: operand_fetch_stage
// PURPOSE
// ID/EX boundary stage consuming the register file's read ports. Drives rf read
// addresses from the decoded instruction, muxes rf read data with two bypass
// sources, detects load-use hazards, and registers operands into EX.
// Inserts bubbles, honours downstream hold, and supports flush on branch redirect.
// PARAMETERS
// ADDR_WIDTH  5   register address width (32 registers; r0 hard-wired zero)
// WORD_WIDTH  32  datapath word width
// CNT_WIDTH   16  width of the load-use stall counter
// PORTS
// clk          in   1   clock; all state updates on posedge
// rst          in   1   asynchronous, active-high reset
// id_valid     in   1   decoded instruction present
// id_ready     out  1   stage accepts the ID instruction this cycle
// id_rs        in   AW  source A register
// id_rt        in   AW  source B register
// id_uses_rs   in   1   instruction reads rs
// id_uses_rt   in   1   instruction reads rt
// id_dest      in   AW  destination register
// id_we        in   1   instruction writes a register
// id_is_load   in   1   instruction is a load
// id_imm       in   WW  sign-extended immediate
// rf_rd_addrA  out  AW  = id_rs (combinational)
// rf_rd_addrB  out  AW  = id_rt (combinational)
// rf_rd_dataA  in   WW  rf read data A (combinational read)
// rf_rd_dataB  in   WW  rf read data B
// f1_en/f1_addr/f1_data/f1_is_load  in 1/AW/WW/1  bypass from instruction in EX
// f2_en/f2_addr/f2_data             in 1/AW/WW    bypass from writeback (the rf write this cycle)
// ex_hold      in   1   EX cannot accept; output register holds
// flush        in   1   discard ID/EX contents (branch redirect)
// ex_valid     out  1   EX register holds a live instruction
// ex_opA/ex_opB out WW  resolved operands
// ex_dest/ex_we/ex_is_load/ex_imm  out AW/1/1/WW  registered copies of ID fields
// stall_cnt    out  CW  count of load-use bubbles inserted
// BEHAVIOUR
// - Reset (async, rst=1): ex_valid=0, ex_opA/ex_opB/ex_imm=0, ex_dest=0, ex_we=0,
//   ex_is_load=0, stall_cnt=0. rst release takes effect on next posedge.
// - Operand resolve, per source (A: rs, B: rt), combinational, priority order:
//   addr==0 -> 0; f1_en & f1_addr==addr & !f1_is_load -> f1_data;
//   f2_en & f2_addr==addr -> f2_data; else rf data. (f2 bypass required: rf
//   write lands at posedge, not visible to the same-cycle read.)
// - hazard = id_valid & f1_en & f1_is_load & f1_addr!=0 &
//   ((id_uses_rs & id_rs==f1_addr) | (id_uses_rt & id_rt==f1_addr)).
// - id_ready = !ex_hold & !hazard. Unused sources never cause hazards.
// - Output register update, priority: flush > ex_hold > hazard > normal.
//   flush: ex_valid<=0; ID instruction accepted if id_ready and discarded.
//   ex_hold: all ex_* hold (hazard ignored; no bubble, no count).
//   hazard: ex_valid<=0 (bubble), other ex_* don't-care; stall_cnt+=1.
//   normal: ex_valid<=id_valid; ex_opA/B, dest, we, is_load, imm captured.
// - Latency: ID to ex_* = 1 cycle; load-use adds exactly 1 bubble.
// - ex_we forced 0 when id_dest==0.
// - stall_cnt saturates at 2^CW-1; no wrap.
// - rst mid-stall clears bubble state and counter immediately.
// TESTING
// 1 rs=3, rf A=0x11, no bypass -> next cycle ex_valid=1, ex_opA=0x11.
// 2 rs=rt=5, f1 (alu, addr5, 0xAA), f2 (addr5, 0xBB) -> opA=opB=0xAA; f1_en=0 -> 0xBB.
// 3 rs=0, f1_addr=0 data 0xFF -> opA=0, no hazard.
// 4 f1 load to r7, ID uses rt=7 -> id_ready=0, ex_valid=0 one cycle, stall_cnt=1;
//   next cycle f1 cleared, f2=(r7, 0x77) -> opB=0x77.
// 5 ex_hold=1 for 3 cycles with id_valid=1 -> ex_* unchanged, id_ready=0;
//   flush and hazard together -> ex_valid=0, stall_cnt unchanged.
// 6 assert rst mid-hazard -> all outputs 0 immediately; force 65540 bubbles -> stall_cnt=0xFFFF.

Source files
------------

// File: rtl/operand_fetch_if.sv
// Bundles the ID-side, register-file, bypass and EX-side signals of the operand fetch stage.
// The stage connects through the slave modport; the producer/consumer side uses master.
interface operand_fetch_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  id_valid;
  logic                  id_ready;
  logic [ADDR_WIDTH-1:0] id_rs;
  logic [ADDR_WIDTH-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic [ADDR_WIDTH-1:0] id_dest;
  logic                  id_we;
  logic                  id_is_load;
  logic [WORD_WIDTH-1:0] id_imm;

  logic [ADDR_WIDTH-1:0] rf_rd_addrA;
  logic [ADDR_WIDTH-1:0] rf_rd_addrB;
  logic [WORD_WIDTH-1:0] rf_rd_dataA;
  logic [WORD_WIDTH-1:0] rf_rd_dataB;

  // Bypass from EX (f1) and from the writeback port (f2)
  logic                  f1_en;
  logic [ADDR_WIDTH-1:0] f1_addr;
  logic [WORD_WIDTH-1:0] f1_data;
  logic                  f1_is_load;
  logic                  f2_en;
  logic [ADDR_WIDTH-1:0] f2_addr;
  logic [WORD_WIDTH-1:0] f2_data;

  logic                  ex_hold;
  logic                  flush;
  logic                  ex_valid;
  logic [WORD_WIDTH-1:0] ex_opA;
  logic [WORD_WIDTH-1:0] ex_opB;
  logic [ADDR_WIDTH-1:0] ex_dest;
  logic                  ex_we;
  logic                  ex_is_load;
  logic [WORD_WIDTH-1:0] ex_imm;
  logic [CNT_WIDTH-1:0]  stall_cnt;

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_we, id_is_load, id_imm,
    input  rf_rd_dataA, rf_rd_dataB,
    input  f1_en, f1_addr, f1_data, f1_is_load, f2_en, f2_addr, f2_data,
    input  ex_hold, flush,
    output id_ready, rf_rd_addrA, rf_rd_addrB,
    output ex_valid, ex_opA, ex_opB, ex_dest, ex_we, ex_is_load, ex_imm, stall_cnt
  );

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_we, id_is_load, id_imm,
    output rf_rd_dataA, rf_rd_dataB,
    output f1_en, f1_addr, f1_data, f1_is_load, f2_en, f2_addr, f2_data,
    output ex_hold, flush,
    input  id_ready, rf_rd_addrA, rf_rd_addrB,
    input  ex_valid, ex_opA, ex_opB, ex_dest, ex_we, ex_is_load, ex_imm, stall_cnt
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// ID/EX operand fetch: resolves rs/rt through two bypass paths, stalls on load-use,
// and registers operands and control into EX with hold and flush support.
module operand_fetch_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic             clk,
  input  logic             rst,
  operand_fetch_if.slave   bus
);

  // EX holds the youngest producer, so it outranks the writeback port; loads in EX
  // have no data yet and are resolved by the hazard stall instead of forwarding.
  function automatic logic [WORD_WIDTH-1:0] resolve(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [WORD_WIDTH-1:0] rf_data,
    input logic                  f1_en,
    input logic [ADDR_WIDTH-1:0] f1_addr,
    input logic [WORD_WIDTH-1:0] f1_data,
    input logic                  f1_is_load,
    input logic                  f2_en,
    input logic [ADDR_WIDTH-1:0] f2_addr,
    input logic [WORD_WIDTH-1:0] f2_data
  );
    logic [WORD_WIDTH-1:0] r;
    if (addr == '0)
      r = '0;
    else if (f1_en && (f1_addr == addr) && !f1_is_load)
      r = f1_data;
    else if (f2_en && (f2_addr == addr))
      r = f2_data;
    else
      r = rf_data;
    return r;
  endfunction

  logic [WORD_WIDTH-1:0] op_a;
  logic [WORD_WIDTH-1:0] op_b;
  logic                  hazard;

  logic                  ex_valid_q,   ex_valid_d;
  logic [WORD_WIDTH-1:0] ex_op_a_q,    ex_op_a_d;
  logic [WORD_WIDTH-1:0] ex_op_b_q,    ex_op_b_d;
  logic [ADDR_WIDTH-1:0] ex_dest_q,    ex_dest_d;
  logic                  ex_we_q,      ex_we_d;
  logic                  ex_is_load_q, ex_is_load_d;
  logic [WORD_WIDTH-1:0] ex_imm_q,     ex_imm_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q,  stall_cnt_d;

  assign bus.rf_rd_addrA = bus.id_rs;
  assign bus.rf_rd_addrB = bus.id_rt;

  always_comb begin
    op_a = resolve(bus.id_rs, bus.rf_rd_dataA, bus.f1_en, bus.f1_addr, bus.f1_data,
                   bus.f1_is_load, bus.f2_en, bus.f2_addr, bus.f2_data);
    op_b = resolve(bus.id_rt, bus.rf_rd_dataB, bus.f1_en, bus.f1_addr, bus.f1_data,
                   bus.f1_is_load, bus.f2_en, bus.f2_addr, bus.f2_data);
  end

  always_comb begin
    hazard = bus.id_valid && bus.f1_en && bus.f1_is_load && (bus.f1_addr != '0) &&
             ((bus.id_uses_rs && (bus.id_rs == bus.f1_addr)) ||
              (bus.id_uses_rt && (bus.id_rt == bus.f1_addr)));
  end

  assign bus.id_ready = !bus.ex_hold && !hazard;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_op_a_d    = ex_op_a_q;
    ex_op_b_d    = ex_op_b_q;
    ex_dest_d    = ex_dest_q;
    ex_we_d      = ex_we_q;
    ex_is_load_d = ex_is_load_q;
    ex_imm_d     = ex_imm_q;
    stall_cnt_d  = stall_cnt_q;

    if (bus.flush) begin
      ex_valid_d = 1'b0;
    end else if (bus.ex_hold) begin
      ex_valid_d = ex_valid_q;
    end else if (hazard) begin
      ex_valid_d  = 1'b0;
      stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + CNT_WIDTH'(1);
    end else begin
      ex_valid_d   = bus.id_valid;
      ex_op_a_d    = op_a;
      ex_op_b_d    = op_b;
      ex_dest_d    = bus.id_dest;
      ex_we_d      = bus.id_we && (bus.id_dest != '0);
      ex_is_load_d = bus.id_is_load;
      ex_imm_d     = bus.id_imm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_op_a_q    <= '0;
      ex_op_b_q    <= '0;
      ex_dest_q    <= '0;
      ex_we_q      <= 1'b0;
      ex_is_load_q <= 1'b0;
      ex_imm_q     <= '0;
      stall_cnt_q  <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_op_a_q    <= ex_op_a_d;
      ex_op_b_q    <= ex_op_b_d;
      ex_dest_q    <= ex_dest_d;
      ex_we_q      <= ex_we_d;
      ex_is_load_q <= ex_is_load_d;
      ex_imm_q     <= ex_imm_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_opA     = ex_op_a_q;
  assign bus.ex_opB     = ex_op_b_q;
  assign bus.ex_dest    = ex_dest_q;
  assign bus.ex_we      = ex_we_q;
  assign bus.ex_is_load = ex_is_load_q;
  assign bus.ex_imm     = ex_imm_q;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: a vector table for the bypass priorities
// plus hand sequences for load-use stall, hold, flush, async reset and saturation.
module tb_operand_fetch_stage;
  localparam int AW = 5;
  localparam int WW = 32;
  localparam int CW = 16;

  typedef struct {
    logic          id_valid;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          uses_rs;
    logic          uses_rt;
    logic [AW-1:0] dest;
    logic          we;
    logic          is_load;
    logic [WW-1:0] imm;
    logic [WW-1:0] rf_a;
    logic [WW-1:0] rf_b;
    logic          f1_en;
    logic [AW-1:0] f1_addr;
    logic [WW-1:0] f1_data;
    logic          f1_is_load;
    logic          f2_en;
    logic [AW-1:0] f2_addr;
    logic [WW-1:0] f2_data;
    logic          ex_hold;
    logic          flush;
    logic          exp_ready;
    logic          exp_valid;
    logic          chk_data;
    logic [WW-1:0] exp_opa;
    logic [WW-1:0] exp_opb;
    logic [AW-1:0] exp_dest;
    logic          exp_we;
    logic          exp_load;
    logic [WW-1:0] exp_imm;
    logic [CW-1:0] exp_stall;
  } vec_t;

  logic clk;
  logic rst;
  int   applied;
  int   miscompares;
  vec_t vecs[$];

  operand_fetch_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .CNT_WIDTH(CW)) bus ();

  operand_fetch_stage #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t blank();
    vec_t v;
    v = '{default: '0};
    v.id_valid = 1'b1;
    v.uses_rs  = 1'b1;
    v.uses_rt  = 1'b1;
    v.exp_ready = 1'b1;
    v.exp_valid = 1'b1;
    v.chk_data  = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.id_valid    = v.id_valid;
    bus.id_rs       = v.rs;
    bus.id_rt       = v.rt;
    bus.id_uses_rs  = v.uses_rs;
    bus.id_uses_rt  = v.uses_rt;
    bus.id_dest     = v.dest;
    bus.id_we       = v.we;
    bus.id_is_load  = v.is_load;
    bus.id_imm      = v.imm;
    bus.rf_rd_dataA = v.rf_a;
    bus.rf_rd_dataB = v.rf_b;
    bus.f1_en       = v.f1_en;
    bus.f1_addr     = v.f1_addr;
    bus.f1_data     = v.f1_data;
    bus.f1_is_load  = v.f1_is_load;
    bus.f2_en       = v.f2_en;
    bus.f2_addr     = v.f2_addr;
    bus.f2_data     = v.f2_data;
    bus.ex_hold     = v.ex_hold;
    bus.flush       = v.flush;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    check({tag, " ex_valid"},  32'(bus.ex_valid),  32'(v.exp_valid));
    check({tag, " stall_cnt"}, 32'(bus.stall_cnt), 32'(v.exp_stall));
    if (v.chk_data) begin
      check({tag, " ex_opA"},     bus.ex_opA,          v.exp_opa);
      check({tag, " ex_opB"},     bus.ex_opB,          v.exp_opb);
      check({tag, " ex_dest"},    32'(bus.ex_dest),    32'(v.exp_dest));
      check({tag, " ex_we"},      32'(bus.ex_we),      32'(v.exp_we));
      check({tag, " ex_is_load"}, 32'(bus.ex_is_load), 32'(v.exp_load));
      check({tag, " ex_imm"},     bus.ex_imm,          v.exp_imm);
    end
  endtask

  // Drive at negedge, check combinational outputs mid-phase, then registered outputs after posedge.
  task automatic runVector(input vec_t v, input int idx);
    @(negedge clk);
    applyStimulus(v);
    #1;
    check($sformatf("v%0d id_ready", idx),    32'(bus.id_ready),    32'(v.exp_ready));
    check($sformatf("v%0d rf_rd_addrA", idx), 32'(bus.rf_rd_addrA), 32'(v.rs));
    check($sformatf("v%0d rf_rd_addrB", idx), 32'(bus.rf_rd_addrB), 32'(v.rt));
    @(posedge clk);
    #1;
    checkOutput(v, idx);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " ex_valid"},   32'(bus.ex_valid),   32'd0);
    check({tag, " ex_opA"},     bus.ex_opA,          32'd0);
    check({tag, " ex_opB"},     bus.ex_opB,          32'd0);
    check({tag, " ex_dest"},    32'(bus.ex_dest),    32'd0);
    check({tag, " ex_we"},      32'(bus.ex_we),      32'd0);
    check({tag, " ex_is_load"}, 32'(bus.ex_is_load), 32'd0);
    check({tag, " ex_imm"},     bus.ex_imm,          32'd0);
    check({tag, " stall_cnt"},  32'(bus.stall_cnt),  32'd0);
  endtask

  initial begin
    vec_t v;
    vec_t hold_v;
    applied     = 0;
    miscompares = 0;
    v = blank();
    v.id_valid = 1'b0;
    applyStimulus(v);
    rst = 1'b1;
    #1;
    checkAllZero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Plain register-file read
    v = blank(); v.rs = 3; v.rt = 4; v.rf_a = 32'h11; v.rf_b = 32'h22; v.dest = 9; v.we = 1;
    v.imm = 32'h100; v.exp_opa = 32'h11; v.exp_opb = 32'h22; v.exp_dest = 9; v.exp_we = 1;
    v.exp_imm = 32'h100; vecs.push_back(v);
    // f1 wins over f2; dest r0 suppresses we
    v = blank(); v.rs = 5; v.rt = 5; v.rf_a = 32'h55; v.rf_b = 32'h66; v.f1_en = 1; v.f1_addr = 5;
    v.f1_data = 32'hAA; v.f2_en = 1; v.f2_addr = 5; v.f2_data = 32'hBB; v.dest = 0; v.we = 1;
    v.imm = 32'hFFFF_FFF0; v.exp_opa = 32'hAA; v.exp_opb = 32'hAA; v.exp_imm = 32'hFFFF_FFF0;
    vecs.push_back(v);
    // f2 alone
    v.f1_en = 0; v.exp_opa = 32'hBB; v.exp_opb = 32'hBB; vecs.push_back(v);
    // f2 on B only, A from rf; load flag carried
    v = blank(); v.rs = 6; v.rt = 8; v.rf_a = 32'h61; v.rf_b = 32'h81; v.f2_en = 1; v.f2_addr = 8;
    v.f2_data = 32'hCC; v.dest = 12; v.we = 1; v.is_load = 1; v.imm = 32'h7;
    v.exp_opa = 32'h61; v.exp_opb = 32'hCC; v.exp_dest = 12; v.exp_we = 1; v.exp_load = 1;
    v.exp_imm = 32'h7; vecs.push_back(v);
    // r0 reads zero and never hazards
    v = blank(); v.rs = 0; v.rt = 0; v.rf_a = 32'h123; v.rf_b = 32'h456; v.f1_en = 1; v.f1_addr = 0;
    v.f1_data = 32'hFF; v.f1_is_load = 1; v.dest = 0; v.we = 1; vecs.push_back(v);
    // Load in EX matching an unused source: no hazard, no forward of load data
    v = blank(); v.rs = 2; v.rt = 7; v.uses_rt = 0; v.rf_a = 32'h2; v.rf_b = 32'h70; v.f1_en = 1;
    v.f1_addr = 7; v.f1_data = 32'hDEAD; v.f1_is_load = 1; v.dest = 5; v.we = 1;
    v.exp_opa = 32'h2; v.exp_opb = 32'h70; v.exp_dest = 5; v.exp_we = 1; vecs.push_back(v);
    // No ID instruction: no hazard, bubble passes through
    v = blank(); v.id_valid = 0; v.rs = 7; v.f1_en = 1; v.f1_addr = 7; v.f1_is_load = 1;
    v.exp_valid = 0; v.chk_data = 0; vecs.push_back(v);
    // Load-use through rs
    v = blank(); v.rs = 7; v.rt = 1; v.f1_en = 1; v.f1_addr = 7; v.f1_is_load = 1;
    v.exp_ready = 0; v.exp_valid = 0; v.chk_data = 0; v.exp_stall = 1; vecs.push_back(v);

    foreach (vecs[i]) runVector(vecs[i], i);

    // Load-use through rt, then resolved by writeback bypass
    v = blank(); v.rs = 2; v.rt = 7; v.rf_a = 32'h22; v.rf_b = 32'h99; v.f1_en = 1; v.f1_addr = 7;
    v.f1_data = 32'hDEAD; v.f1_is_load = 1; v.dest = 10; v.we = 1; v.imm = 32'h44;
    v.exp_ready = 0; v.exp_valid = 0; v.chk_data = 0; v.exp_stall = 2;
    runVector(v, 100);
    v.f1_en = 0; v.f2_en = 1; v.f2_addr = 7; v.f2_data = 32'h77;
    v.exp_ready = 1; v.exp_valid = 1; v.chk_data = 1; v.exp_opa = 32'h22; v.exp_opb = 32'h77;
    v.exp_dest = 10; v.exp_we = 1; v.exp_imm = 32'h44;
    runVector(v, 101);

    // Hold for three cycles, the last with a hazard that must be ignored
    hold_v = v;
    hold_v.rs = 1; hold_v.rt = 2; hold_v.rf_a = 32'hEEEE; hold_v.rf_b = 32'hFFFF; hold_v.f2_en = 0;
    hold_v.dest = 11; hold_v.imm = 32'h99; hold_v.ex_hold = 1; hold_v.exp_ready = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        hold_v.f1_en = 1; hold_v.f1_addr = 2; hold_v.f1_is_load = 1;
      end
      runVector(hold_v, 110 + c);
    end

    // Flush together with hazard
    v = blank(); v.rs = 1; v.rt = 2; v.f1_en = 1; v.f1_addr = 2; v.f1_is_load = 1; v.flush = 1;
    v.exp_ready = 0; v.exp_valid = 0; v.chk_data = 0; v.exp_stall = 2;
    runVector(v, 120);
    // Refill, then flush under hold
    v = blank(); v.rs = 1; v.rt = 3; v.rf_a = 32'h1234; v.rf_b = 32'h3; v.dest = 4; v.we = 1;
    v.exp_opa = 32'h1234; v.exp_opb = 32'h3; v.exp_dest = 4; v.exp_we = 1; v.exp_stall = 2;
    runVector(v, 121);
    v.flush = 1; v.ex_hold = 1; v.exp_ready = 0; v.exp_valid = 0; v.chk_data = 0;
    runVector(v, 122);
    // Refill, then plain flush with an accepted instruction
    v.flush = 0; v.ex_hold = 0; v.exp_ready = 1; v.exp_valid = 1; v.chk_data = 1;
    runVector(v, 123);
    v.flush = 1; v.exp_valid = 0; v.chk_data = 0;
    runVector(v, 124);

    // Async reset in the middle of a stall
    v = blank(); v.rs = 9; v.f1_en = 1; v.f1_addr = 9; v.f1_is_load = 1; v.rf_a = 32'h5A;
    v.exp_ready = 0; v.exp_valid = 0; v.chk_data = 0; v.exp_stall = 3;
    runVector(v, 130);
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("mid-stall reset");
    @(negedge clk);
    rst = 1'b0;

    // Hazard held continuously: counter saturates instead of wrapping
    repeat (65534) @(posedge clk);
    #1;
    check("stall_cnt 65534", 32'(bus.stall_cnt), 32'hFFFE);
    check("id_ready during stall", 32'(bus.id_ready), 32'd0);
    @(posedge clk);
    #1;
    check("stall_cnt 65535", 32'(bus.stall_cnt), 32'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    check("stall_cnt saturated", 32'(bus.stall_cnt), 32'hFFFF);
    check("ex_valid during stall", 32'(bus.ex_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
